// File: rtl/input_command_scheduler.sv
`timescale 1ns/1ps
// input_command_scheduler
// Turns NES controller polls into game commands: press detection, Left/Right
// DAS auto-repeat, Soft-drop repeat, a one-bit-per-command pending set and a
// fixed-priority valid/ready output stage. A RUN/PAUSED machine toggles on each
// accepted PAUSE command.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         synchronous, active-low
//   buttons       poll sample, 1 = pressed: A B Select Start Up Down Left Right
//   buttons_valid one-cycle strobe marking a new poll
//   cmd           1 LEFT 2 RIGHT 3 SOFT_DROP 4 HARD_DROP 5 ROT_CW 6 ROT_CCW 7 PAUSE
//   cmd_valid     cmd holds a command
//   cmd_ready     consumer accepts cmd
//   paused        high while PAUSED
//   cmd_dropped   pulse when an event merges into an already-pending request
//
// state     | meaning
// RUN       | all events accepted
// PAUSED    | only PAUSE accepted, other pending bits flushed, repeaters idle
// ST_IDLE   | DAS: no direction held
// ST_CHARGE | DAS: direction held, counting up to DAS_DELAY polls
// ST_REPEAT | DAS: auto-repeating every DAS_REPEAT polls
module input_command_scheduler #(
   parameter int unsigned DAS_DELAY   = 16,
   parameter int unsigned DAS_REPEAT  = 6,
   parameter int unsigned SOFT_REPEAT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] buttons,
   input  logic       buttons_valid,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       paused,
   output logic       cmd_dropped
);

   typedef enum logic {RUN, PAUSED} run_state_t;
   typedef enum logic [1:0] {ST_IDLE, ST_CHARGE, ST_REPEAT} das_state_t;

   localparam logic [7:0] DELAY_TC  = 8'(DAS_DELAY);
   localparam logic [7:0] REPEAT_TC = 8'(DAS_REPEAT);
   localparam logic [7:0] SOFT_TC   = 8'(SOFT_REPEAT);

   // pending bit i holds command i+1
   localparam logic [6:0] PAUSE_BIT = 7'b1000000;

   run_state_t run_q, run_d;
   das_state_t das_q, das_d;
   logic [7:0] das_cnt_q, das_cnt_d;
   logic       soft_on_q, soft_on_d;
   logic [7:0] soft_cnt_q, soft_cnt_d;
   logic [7:0] prev_q;
   logic       primed_q;
   logic [6:0] pending_q, pending_d;
   logic [2:0] cmd_d;
   logic       cmd_valid_d;
   logic       dropped_d;

   logic [6:0] ev;
   logic [6:0] sel_mask;
   logic [2:0] sel_cmd;
   logic [6:0] load_mask;
   logic       load;
   logic       handshake;
   logic       left_eff, right_eff, left_edge, right_edge;
   logic       down_edge;
   logic [7:0] rise;
   logic [7:0] das_inc, soft_inc;
   logic       unused_select;

   assign unused_select = buttons[5] ^ prev_q[5];
   assign paused        = (run_q == PAUSED);

   always_comb begin
      das_d      = das_q;
      das_cnt_d  = das_cnt_q;
      soft_on_d  = soft_on_q;
      soft_cnt_d = soft_cnt_q;
      run_d      = run_q;
      ev         = '0;
      das_inc    = das_cnt_q + 8'd1;
      soft_inc   = soft_cnt_q + 8'd1;

      // The priming poll sees no rising edges, but a held direction still
      // starts charging so the first repeat lands DAS_DELAY polls later.
      rise       = primed_q ? (buttons & ~prev_q) : 8'h00;
      left_eff   = buttons[1] & ~buttons[0];
      right_eff  = buttons[0] & ~buttons[1];
      left_edge  = primed_q & left_eff  & ~(prev_q[1] & ~prev_q[0]);
      right_edge = primed_q & right_eff & ~(prev_q[0] & ~prev_q[1]);
      down_edge  = rise[2];

      if (buttons_valid) begin
         ev[3] = rise[3];
         ev[4] = rise[7];
         ev[5] = rise[6];
         ev[6] = rise[4];

         if (!(left_eff || right_eff)) begin
            das_d     = ST_IDLE;
            das_cnt_d = '0;
         end else if (left_edge || right_edge) begin
            ev[0]     = left_edge;
            ev[1]     = right_edge;
            das_d     = ST_CHARGE;
            das_cnt_d = '0;
         end else if (das_q == ST_IDLE) begin
            das_d     = ST_CHARGE;
            das_cnt_d = '0;
         end else if ((das_q == ST_CHARGE && das_inc == DELAY_TC) ||
                      (das_q == ST_REPEAT && das_inc == REPEAT_TC)) begin
            ev[0]     = left_eff;
            ev[1]     = right_eff;
            das_d     = ST_REPEAT;
            das_cnt_d = '0;
         end else begin
            das_cnt_d = das_inc;
         end

         if (!buttons[2]) begin
            soft_on_d  = 1'b0;
            soft_cnt_d = '0;
         end else if (down_edge) begin
            ev[2]      = 1'b1;
            soft_on_d  = 1'b1;
            soft_cnt_d = '0;
         end else if (!soft_on_q) begin
            soft_on_d  = 1'b1;
            soft_cnt_d = '0;
         end else if (soft_inc == SOFT_TC) begin
            ev[2]      = 1'b1;
            soft_cnt_d = '0;
         end else begin
            soft_cnt_d = soft_inc;
         end
      end

      if (run_q == PAUSED) begin
         ev         = ev & PAUSE_BIT;
         das_d      = ST_IDLE;
         das_cnt_d  = '0;
         soft_on_d  = 1'b0;
         soft_cnt_d = '0;
      end

      sel_cmd  = 3'd0;
      sel_mask = '0;
      if      (pending_q[6]) begin sel_cmd = 3'd7; sel_mask = 7'b1000000; end
      else if (pending_q[3]) begin sel_cmd = 3'd4; sel_mask = 7'b0001000; end
      else if (pending_q[4]) begin sel_cmd = 3'd5; sel_mask = 7'b0010000; end
      else if (pending_q[5]) begin sel_cmd = 3'd6; sel_mask = 7'b0100000; end
      else if (pending_q[0]) begin sel_cmd = 3'd1; sel_mask = 7'b0000001; end
      else if (pending_q[1]) begin sel_cmd = 3'd2; sel_mask = 7'b0000010; end
      else if (pending_q[2]) begin sel_cmd = 3'd3; sel_mask = 7'b0000100; end

      handshake   = cmd_valid & cmd_ready;
      load        = ~cmd_valid | handshake;
      load_mask   = load ? sel_mask : 7'b0;
      cmd_d       = load ? sel_cmd : cmd;
      cmd_valid_d = load ? (|pending_q) : cmd_valid;

      if (handshake && cmd == 3'd7)
         run_d = (run_q == RUN) ? PAUSED : RUN;

      // A bit being loaded this edge is free again, so a coinciding event
      // re-arms it instead of counting as a drop.
      dropped_d = |(ev & pending_q & ~load_mask);
      pending_d = (pending_q & ~load_mask) | ev;
      if (run_q == PAUSED)
         pending_d = pending_d & PAUSE_BIT;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         run_q       <= RUN;
         das_q       <= ST_IDLE;
         das_cnt_q   <= '0;
         soft_on_q   <= 1'b0;
         soft_cnt_q  <= '0;
         prev_q      <= '0;
         primed_q    <= 1'b0;
         pending_q   <= '0;
         cmd         <= '0;
         cmd_valid   <= 1'b0;
         cmd_dropped <= 1'b0;
      end else begin
         run_q       <= run_d;
         das_q       <= das_d;
         das_cnt_q   <= das_cnt_d;
         soft_on_q   <= soft_on_d;
         soft_cnt_q  <= soft_cnt_d;
         pending_q   <= pending_d;
         cmd         <= cmd_d;
         cmd_valid   <= cmd_valid_d;
         cmd_dropped <= dropped_d;
         if (buttons_valid) begin
            prev_q   <= buttons;
            primed_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_input_command_scheduler.sv
`timescale 1ns/1ps
module tb_input_command_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       paused;
   logic       cmd_dropped;

   int checks = 0;
   int errors = 0;

   input_command_scheduler dut (
      .clk(clk), .reset(reset), .buttons(buttons), .buttons_valid(buttons_valid),
      .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .paused(paused), .cmd_dropped(cmd_dropped)
   );

   always #12.5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poll(input logic [7:0] b);
      buttons       = b;
      buttons_valid = 1'b1;
      tick();
      buttons_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      buttons_valid = 1'b0;
      tick();
      reset         = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({cmd, cmd_valid, paused, cmd_dropped} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got cmd=%0d v=%0b p=%0b d=%0b want all 0",
                  cmd, cmd_valid, paused, cmd_dropped);
      end
   endtask

   task automatic test_das();
      logic exp;
      do_reset();
      cmd_ready = 1'b1;
      poll(8'h02);
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL das_priming got cmd_valid=%0b want 0", cmd_valid);
      end
      tick();
      for (int k = 1; k <= 40; k++) begin
         poll(8'h02);
         tick();
         exp = (k >= 16) && (((k - 16) % 6) == 0);
         checks++;
         if (cmd_valid !== exp || (exp && cmd !== 3'd1)) begin
            errors++;
            $display("FAIL das_hold_%0d got v=%0b cmd=%0d want v=%0b cmd=1",
                     k, cmd_valid, cmd, exp);
         end
         tick();
      end
      poll(8'h00);
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      cmd_ready = 1'b1;
      poll(8'h00);
      tick();
      poll(8'h98);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd7 || paused !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first got v=%0b cmd=%0d p=%0b want 1 7 0", cmd_valid, cmd, paused);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd4 || paused !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got v=%0b cmd=%0d p=%0b want 1 4 1", cmd_valid, cmd, paused);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
         errors++;
         $display("FAIL b2b_third got v=%0b cmd=%0d want 1 5", cmd_valid, cmd);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b0 || paused !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain got v=%0b p=%0b want 0 1", cmd_valid, paused);
      end
   endtask

   task automatic test_paused();
      logic [7:0] seq [6];
      seq = '{8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h80};
      for (int i = 0; i < 6; i++) begin
         poll(seq[i]);
         tick();
         checks++;
         if (cmd_valid !== 1'b0 || paused !== 1'b1) begin
            errors++;
            $display("FAIL paused_discard_%0d got v=%0b cmd=%0d p=%0b want v=0 p=1",
                     i, cmd_valid, cmd, paused);
         end
      end
      poll(8'h10);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd7 || paused !== 1'b1) begin
         errors++;
         $display("FAIL paused_resume_cmd got v=%0b cmd=%0d p=%0b want 1 7 1", cmd_valid, cmd, paused);
      end
      tick();
      checks++;
      if (paused !== 1'b0 || cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL paused_resume_state got p=%0b v=%0b want 0 0", paused, cmd_valid);
      end
      poll(8'h00);
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL paused_no_stale got v=%0b cmd=%0d want 0", cmd_valid, cmd);
      end
   endtask

   task automatic test_soft_drop();
      logic exp_drop;
      int   drops;
      drops = 0;
      do_reset();
      cmd_ready = 1'b0;
      poll(8'h00);
      poll(8'h04);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd3 || cmd_dropped !== 1'b0) begin
         errors++;
         $display("FAIL soft_first got v=%0b cmd=%0d d=%0b want 1 3 0", cmd_valid, cmd, cmd_dropped);
      end
      for (int k = 1; k <= 6; k++) begin
         poll(8'h04);
         exp_drop = (k == 4) || (k == 6);
         if (cmd_dropped === 1'b1) drops++;
         checks++;
         if (cmd_dropped !== exp_drop || cmd_valid !== 1'b1 || cmd !== 3'd3) begin
            errors++;
            $display("FAIL soft_hold_%0d got d=%0b v=%0b cmd=%0d want d=%0b v=1 cmd=3",
                     k, cmd_dropped, cmd_valid, cmd, exp_drop);
         end
         tick();
         checks++;
         if (cmd_dropped !== 1'b0) begin
            errors++;
            $display("FAIL soft_pulse_%0d got d=%0b want 0", k, cmd_dropped);
         end
      end
      checks++;
      if (drops !== 2) begin
         errors++;
         $display("FAIL soft_drop_count got %0d want 2", drops);
      end
      cmd_ready = 1'b1;
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
         errors++;
         $display("FAIL soft_pending_one got v=%0b cmd=%0d want 1 3", cmd_valid, cmd);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL soft_pending_empty got v=%0b want 0", cmd_valid);
      end
      poll(8'h00);
      tick();
   endtask

   task automatic test_left_right();
      do_reset();
      cmd_ready = 1'b1;
      poll(8'h00);
      tick();
      for (int i = 0; i < 2; i++) begin
         poll(8'h03);
         tick();
         checks++;
         if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL lr_both_%0d got v=%0b cmd=%0d want 0", i, cmd_valid, cmd);
         end
         tick();
      end
      poll(8'h02);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
         errors++;
         $display("FAIL lr_release_right got v=%0b cmd=%0d want 1 1", cmd_valid, cmd);
      end
      tick();
      poll(8'h01);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
         errors++;
         $display("FAIL lr_dir_change got v=%0b cmd=%0d want 1 2", cmd_valid, cmd);
      end
      tick();
      poll(8'h00);
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      cmd_ready = 1'b0;
      poll(8'h00);
      poll(8'h45);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd6) begin
         errors++;
         $display("FAIL prio_first got v=%0b cmd=%0d want 1 6", cmd_valid, cmd);
      end
      tick();
      checks++;
      if (cmd !== 3'd6) begin
         errors++;
         $display("FAIL prio_stall got cmd=%0d want 6", cmd);
      end
      cmd_ready = 1'b1;
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
         errors++;
         $display("FAIL prio_second got v=%0b cmd=%0d want 1 2", cmd_valid, cmd);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
         errors++;
         $display("FAIL prio_third got v=%0b cmd=%0d want 1 3", cmd_valid, cmd);
      end
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL prio_drain got v=%0b want 0", cmd_valid);
      end
      poll(8'h00);
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      cmd_ready = 1'b0;
      poll(8'h00);
      poll(8'h80);
      tick();
      poll(8'hC0);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
         errors++;
         $display("FAIL rmid_setup got v=%0b cmd=%0d want 1 5", cmd_valid, cmd);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (cmd_valid !== 1'b0 || cmd !== 3'd0 || paused !== 1'b0 || cmd_dropped !== 1'b0) begin
         errors++;
         $display("FAIL rmid_outputs got v=%0b cmd=%0d p=%0b d=%0b want all 0",
                  cmd_valid, cmd, paused, cmd_dropped);
      end
      cmd_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_pending_cleared got v=%0b cmd=%0d want 0", cmd_valid, cmd);
      end
      poll(8'h08);
      tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rmid_priming got v=%0b cmd=%0d want 0", cmd_valid, cmd);
      end
      poll(8'h00);
      poll(8'h08);
      tick();
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
         errors++;
         $display("FAIL rmid_after got v=%0b cmd=%0d want 1 4", cmd_valid, cmd);
      end
      tick();
   endtask

   initial begin
      reset         = 1'b0;
      buttons       = 8'h00;
      buttons_valid = 1'b0;
      cmd_ready     = 1'b0;
      tick();
      tick();
      test_reset();
      reset = 1'b1;
      test_das();
      test_back_to_back();
      test_paused();
      test_soft_drop();
      test_left_right();
      test_priority();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
